// File: rtl/row_writeback.sv
// Result-row write-back: two-entry row FIFO feeding a word serialiser onto the
// generation BRAM write port, with ping-pong bank selection per frame.
module row_writeback #(
    parameter int unsigned ROW_CELLS = 1280,
    parameter int unsigned ROWS      = 720,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned ROW_W     = 10,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                 out_stream_aclk,
    input  logic                 out_stream_aresetn,
    input  logic                 row_valid,
    input  logic [ROW_W-1:0]     row_addr,
    input  logic [ROW_CELLS-1:0] row_data,
    output logic                 row_ready,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic [WORD_W-1:0]    bram_din,
    output logic                 bram_we,
    output logic                 bank_sel,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 err_drop
);

    localparam int unsigned WORDS_PER_ROW = ROW_CELLS / WORD_W;
    localparam int unsigned K_W           = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int unsigned BANK_WORDS    = ROWS * WORDS_PER_ROW;

    typedef enum logic {IDLE, WRITE} state_e;

    state_e               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d, k_cur;
    logic [1:0]           count_q, count_d;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [ROW_W-1:0]     fifo_addr_q [2];
    logic [ROW_CELLS-1:0] fifo_data_q [2];
    logic                 row_ready_q, bram_we_q, bank_q, frame_pend_q, frame_done_q;
    logic                 busy_q, err_q;
    logic [ADDR_W-1:0]    bram_addr_q, addr_d;
    logic [WORD_W-1:0]    bram_din_q, din_d;
    logic                 push, pop, issue, last_word, head_ok, frame_pend_d, busy_d, err_d;
    logic [ROW_W-1:0]     head_addr;

    // row * WORDS_PER_ROW as a sum of shifted copies of the row index
    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            if (WORDS_PER_ROW[i]) acc = acc + (ADDR_W'(row) << i);
        end
        return acc;
    endfunction

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        push         = row_valid && row_ready_q;
        pop          = 1'b0;
        issue        = 1'b0;
        err_d        = err_q || (row_valid && !row_ready_q);
        head_addr    = fifo_addr_q[rd_ptr_q];
        head_ok      = 32'(head_addr) < ROWS;
        k_cur        = (state_q == WRITE) ? k_q : '0;
        last_word    = (k_cur == K_W'(WORDS_PER_ROW - 1));
        // Queued rows behind the frame's last row already target the new bank
        addr_d       = ((bank_q ^ frame_pend_q) ? ADDR_W'(BANK_WORDS) : '0)
                       + row_base(head_addr) + ADDR_W'(k_cur);
        din_d        = fifo_data_q[rd_ptr_q][int'(k_cur) * WORD_W +: WORD_W];
        frame_pend_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    if (head_ok) begin
                        issue = 1'b1;
                    end else begin
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: issue = 1'b1;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            if (last_word) begin
                pop          = 1'b1;
                state_d      = IDLE;
                k_d          = '0;
                frame_pend_d = (32'(head_addr) == ROWS - 1);
            end else begin
                state_d = WRITE;
                k_d     = k_cur + K_W'(1);
            end
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
        busy_d = (count_d != 2'd0) || (state_d == WRITE) || issue;
    end

    always_ff @(posedge out_stream_aclk or negedge out_stream_aresetn) begin
        if (!out_stream_aresetn) begin
            state_q      <= IDLE;
            k_q          <= '0;
            count_q      <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            row_ready_q  <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            bank_q       <= 1'b0;
            frame_pend_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_q ^ push;
            rd_ptr_q     <= rd_ptr_q ^ pop;
            row_ready_q  <= (count_d < 2'd2);
            bram_we_q    <= issue;
            if (issue) begin
                bram_addr_q <= addr_d;
                bram_din_q  <= din_d;
            end
            frame_pend_q <= frame_pend_d;
            frame_done_q <= frame_pend_q;
            bank_q       <= bank_q ^ frame_pend_q;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // Row storage needs no reset: entries are only read once counted valid
    always_ff @(posedge out_stream_aclk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= row_addr;
            fifo_data_q[wr_ptr_q] <= row_data;
        end
    end

    assign row_ready  = row_ready_q;
    assign bram_addr  = bram_addr_q;
    assign bram_din   = bram_din_q;
    assign bram_we    = bram_we_q;
    assign bank_sel   = bank_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign err_drop   = err_q;

endmodule

// File: tb/tb_row_writeback.sv
// Bench for row_writeback: a queue-based model predicts every BRAM write,
// frame_done pulse and bank state from the rows pushed.
`timescale 1ns/1ps
module tb_row_writeback;

    localparam int unsigned ROW_CELLS  = 1280;
    localparam int unsigned ROWS       = 720;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ROW_W      = 10;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned WPR        = ROW_CELLS / WORD_W;
    localparam int unsigned BANK_WORDS = ROWS * WPR;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 row_valid = 1'b0;
    logic [ROW_W-1:0]     row_addr = '0;
    logic [ROW_CELLS-1:0] row_data = '0;
    logic                 row_ready, bram_we, bank_sel, frame_done, busy, err_drop;
    logic [ADDR_W-1:0]    bram_addr;
    logic [WORD_W-1:0]    bram_din;

    row_writeback #(
        .ROW_CELLS(ROW_CELLS), .ROWS(ROWS), .WORD_W(WORD_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
    ) dut (
        .out_stream_aclk(clk), .out_stream_aresetn(rst_n),
        .row_valid(row_valid), .row_addr(row_addr), .row_data(row_data), .row_ready(row_ready),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bank_sel(bank_sel),
        .frame_done(frame_done), .busy(busy), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] din;
        int                cyc;
        bit                eof;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  fd_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  m_bank = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_we) obs_q.push_back('{addr: bram_addr, din: bram_din, cyc: cyc, eof: 1'b0});
            if (frame_done) fd_q.push_back(cyc);
        end
    end

    // Every in-range row becomes WPR writes into the current bank; row ROWS-1 flips the bank
    function automatic void model_row(input int unsigned r, input logic [ROW_CELLS-1:0] d);
        wr_t w;
        if (r >= ROWS) return;
        for (int unsigned k = 0; k < WPR; k++) begin
            w.addr = ADDR_W'((m_bank ? BANK_WORDS : 0) + r * WPR + k);
            w.din  = d[k*WORD_W +: WORD_W];
            w.cyc  = 0;
            w.eof  = (r == ROWS - 1) && (k == WPR - 1);
            exp_q.push_back(w);
        end
        if (r == ROWS - 1) m_bank = ~m_bank;
    endfunction

    function automatic logic [ROW_CELLS-1:0] ramp_row(input logic [WORD_W-1:0] base);
        logic [ROW_CELLS-1:0] d;
        for (int unsigned k = 0; k < WPR; k++) d[k*WORD_W +: WORD_W] = base + WORD_W'(k);
        return d;
    endfunction

    function automatic logic [ROW_CELLS-1:0] rand_row();
        logic [ROW_CELLS-1:0] d;
        for (int unsigned k = 0; k < WPR; k++) d[k*WORD_W +: WORD_W] = $urandom;
        return d;
    endfunction

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        fd_q.delete();
    endtask

    task automatic drive_row(input int unsigned r, input logic [ROW_CELLS-1:0] d,
                             output bit rdy, output int pc);
        @(negedge clk);
        row_valid = 1'b1;
        row_addr  = ROW_W'(r);
        row_data  = d;
        rdy       = row_ready;
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        pc        = cyc;
    endtask

    task automatic drain(output bit to);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        to = busy;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({row_ready, bram_we, bank_sel, frame_done, busy, err_drop} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {row_ready, bram_we, bank_sel, frame_done, busy, err_drop});
        end
        checks++;
        if (bram_addr !== '0 || bram_din !== '0) begin
            errors++;
            $display("FAIL reset_bus got %h/%h want 0/0", bram_addr, bram_din);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (row_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b want 1/0", row_ready, busy);
        end
    endtask

    task automatic test_single_rows();
        bit rdy, to;
        int pc;
        logic [ROW_CELLS-1:0] d;
        clear_queues();
        d = ramp_row(32'hA000_0000);
        drive_row(0, d, rdy, pc);
        model_row(0, d);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b want 1", rdy); end
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL single_drain0 got busy=1 want 0"); end
        checks++;
        if (obs_q.size() > 0 && obs_q[0].cyc !== pc + 1) begin
            errors++;
            $display("FAIL single_latency got cycle %0d want %0d", obs_q[0].cyc, pc + 1);
        end
        d = rand_row();
        drive_row(5, d, rdy, pc);
        model_row(5, d);
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL single_drain5 got busy=1 want 0"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].din !== exp_q[i].din) begin
                errors++;
                $display("FAIL single_word[%0d] got %0d/%h want %0d/%h", i,
                         obs_q[i].addr, obs_q[i].din, exp_q[i].addr, exp_q[i].din);
            end
        end
        checks++;
        if (fd_q.size() != 0) begin
            errors++;
            $display("FAIL single_frame_done got %0d pulses want 0", fd_q.size());
        end
    endtask

    task automatic test_frame_end();
        bit rdy, to;
        int pc;
        int efd[$];
        logic [ROW_CELLS-1:0] d;
        clear_queues();
        d = rand_row();
        drive_row(ROWS - 1, d, rdy, pc);
        model_row(ROWS - 1, d);
        drain(to);
        checks++;
        if (bank_sel !== m_bank) begin
            errors++;
            $display("FAIL frame_bank got %b want %b", bank_sel, m_bank);
        end
        d = rand_row();
        drive_row(0, d, rdy, pc);
        model_row(0, d);
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL frame_drain got busy=1 want 0"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].din !== exp_q[i].din) begin
                errors++;
                $display("FAIL frame_word[%0d] got %0d/%h want %0d/%h", i,
                         obs_q[i].addr, obs_q[i].din, exp_q[i].addr, exp_q[i].din);
            end
            if (exp_q[i].eof) efd.push_back(obs_q[i].cyc + 1);
        end
        checks++;
        if (fd_q.size() != efd.size()) begin
            errors++;
            $display("FAIL frame_pulses got %0d want %0d", fd_q.size(), efd.size());
        end
        for (int i = 0; i < fd_q.size() && i < efd.size(); i++) begin
            checks++;
            if (fd_q[i] != efd[i]) begin
                errors++;
                $display("FAIL frame_pulse_cycle[%0d] got %0d want %0d", i, fd_q[i], efd[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        bit rdy, to;
        int pc;
        clear_queues();
        checks++;
        if (err_drop !== 1'b0) begin errors++; $display("FAIL oor_err_before got %b want 0", err_drop); end
        drive_row(ROWS, rand_row(), rdy, pc);
        drain(to);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL oor_writes got %0d want 0", obs_q.size());
        end
        checks++;
        if ({err_drop, busy, row_ready} !== 3'b101) begin
            errors++;
            $display("FAIL oor_state got err/busy/ready=%b want 101", {err_drop, busy, row_ready});
        end
    endtask

    task automatic test_reset_mid_row();
        bit rdy;
        int pc, n;
        clear_queues();
        drive_row(3, rand_row(), rdy, pc);
        n = 0;
        while (obs_q.size() < 17 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (bram_we !== 1'b1) begin errors++; $display("FAIL midrst_pre_we got %b want 1", bram_we); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bram_we !== 1'b0) begin errors++; $display("FAIL midrst_we got %b want 0", bram_we); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_bank = 1'b0;
        clear_queues();
        repeat (2) @(negedge clk);
        checks++;
        if ({row_ready, busy, bank_sel, err_drop} !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_state got ready/busy/bank/err=%b want 1000",
                     {row_ready, busy, bank_sel, err_drop});
        end
        repeat (50) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_resume got %0d writes want 0", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit r0, r1, r2, to;
        int pc;
        logic [ROW_CELLS-1:0] d0, d1;
        clear_queues();
        d0 = rand_row();
        d1 = rand_row();
        drive_row(0, d0, r0, pc);
        drive_row(1, d1, r1, pc);
        drive_row(2, rand_row(), r2, pc);
        model_row(0, d0);
        model_row(1, d1);
        @(negedge clk);
        checks++;
        if ({r0, r1, r2} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_ready_seq got %b want 110", {r0, r1, r2});
        end
        checks++;
        if (row_ready !== 1'b0 || err_drop !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full got ready=%b err=%b want 0/1", row_ready, err_drop);
        end
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL b2b_drain got busy=1 want 0"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].din !== exp_q[i].din) begin
                errors++;
                $display("FAIL b2b_word[%0d] got %0d/%h want %0d/%h", i,
                         obs_q[i].addr, obs_q[i].din, exp_q[i].addr, exp_q[i].din);
            end
        end
        checks++;
        if (obs_q.size() == 2 * WPR && obs_q[2*WPR-1].cyc - obs_q[0].cyc != int'(2 * WPR - 1)) begin
            errors++;
            $display("FAIL b2b_contiguous got span %0d want %0d",
                     obs_q[2*WPR-1].cyc - obs_q[0].cyc, 2 * WPR - 1);
        end
    endtask

    task automatic test_random();
        bit rdy, to;
        int pc, n, efd[$];
        int unsigned r;
        logic [ROW_CELLS-1:0] d;
        clear_queues();
        for (int j = 0; j < 10; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n = 0;
            while (!row_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            r = ($urandom_range(0, 3) == 0) ? ROWS - 1 : $urandom_range(0, ROWS - 1);
            d = rand_row();
            drive_row(r, d, rdy, pc);
            model_row(r, d);
            checks++;
            if (rdy !== 1'b1) begin errors++; $display("FAIL rand_ready[%0d] got %b want 1", j, rdy); end
        end
        drain(to);
        checks++;
        if (to) begin errors++; $display("FAIL rand_drain got busy=1 want 0"); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].din !== exp_q[i].din) begin
                errors++;
                $display("FAIL rand_word[%0d] got %0d/%h want %0d/%h", i,
                         obs_q[i].addr, obs_q[i].din, exp_q[i].addr, exp_q[i].din);
            end
            if (exp_q[i].eof) efd.push_back(obs_q[i].cyc + 1);
        end
        checks++;
        if (fd_q.size() != efd.size()) begin
            errors++;
            $display("FAIL rand_pulses got %0d want %0d", fd_q.size(), efd.size());
        end
        for (int i = 0; i < fd_q.size() && i < efd.size(); i++) begin
            checks++;
            if (fd_q[i] != efd[i]) begin
                errors++;
                $display("FAIL rand_pulse_cycle[%0d] got %0d want %0d", i, fd_q[i], efd[i]);
            end
        end
        checks++;
        if (bank_sel !== m_bank) begin
            errors++;
            $display("FAIL rand_bank got %b want %b", bank_sel, m_bank);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_rows();
        test_frame_end();
        test_out_of_range();
        test_reset_mid_row();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_writeback.md
Name: row_writeback

Overview:
- Downstream stage of parallel_next_state in the cellular-automaton next-state pipeline.
- Accepts one computed result row per handshake, buffers up to two rows, and serialises each row into WORD_W-bit writes on the generation BRAM write port.
- Manages ping-pong bank selection between generations and signals frame completion to the line iterator and the display side.

Parameters:
ROW_CELLS, 1280, cells per row (result row width in bits)
ROWS, 720, rows per frame
WORD_W, 32, BRAM data width; ROW_CELLS must be a multiple of WORD_W
WORDS_PER_ROW, ROW_CELLS/WORD_W (40), BRAM words per row
ROW_W, 10, row index width
ADDR_W, 16, BRAM word-address width; must satisfy 2*ROWS*WORDS_PER_ROW <= 2^ADDR_W

Ports:
out_stream_aclk  in  1  clock
out_stream_aresetn  in  1  asynchronous active-low reset
row_valid  in  1  result row present (from parallel_next_state write_en)
row_addr  in  ROW_W  row index of result (from write_addr)
row_data  in  ROW_CELLS  next-state row (from result); bit i = cell column i
row_ready  out  1  buffer can accept a row
bram_addr  out  ADDR_W  BRAM word address
bram_din  out  WORD_W  BRAM write data
bram_we  out  1  BRAM write enable
bank_sel  out  1  bank currently being written; read side uses ~bank_sel
frame_done  out  1  one-cycle pulse when last word of row ROWS-1 is written
busy  out  1  FIFO non-empty or serialiser active
err_drop  out  1  sticky: row lost (overflow or out-of-range index)

Behaviour:
- Reset (async assert, sync release): all outputs 0. FIFO count 0, word counter 0, FSM IDLE, bank_sel 0. Any in-progress row is abandoned; bram_we drops immediately on reset assertion.
- FIFO: 2 entries of {row_addr, row_data}. row_ready = (count < 2), registered from count. A full FIFO is not ready, even if a pop occurs in the same cycle. Push and pop in the same cycle leave count unchanged.
- Accept: row_valid && row_ready at a rising edge pushes the entry.
- Overflow: row_valid && !row_ready discards the row and sets err_drop.
- Out-of-range index: an accepted row with row_addr >= ROWS is popped without any writes and sets err_drop.
- err_drop is cleared only by reset.
- FSM, IDLE:
  - FIFO non-empty → load the head entry, word index k = 0, row base = row*WORDS_PER_ROW computed by shift-add (row<<5 + row<<3 for the defaults).
  - Go to WRITE on the next edge.
- FSM, WRITE: one word per cycle, bram_we = 1 for exactly WORDS_PER_ROW consecutive cycles.
  - bram_din = row_data[k*WORD_W +: WORD_W].
  - bram_addr = bank_sel*ROWS*WORDS_PER_ROW + row_base + k.
  - After k = WORDS_PER_ROW-1, pop the entry.
  - If the FIFO still holds another row, reload it and start k = 0 in the next cycle (no bubble). Otherwise return to IDLE.
- Latency: a row accepted at edge t into an empty FIFO with the FSM in IDLE produces its first bram_we in the cycle after edge t+1. Sustained throughput is one row per WORDS_PER_ROW cycles.
- Frame end: when the final word of row ROWS-1 is written:
  - frame_done pulses high for one cycle in the next cycle.
  - bank_sel toggles on the same edge that raises frame_done.
  - Any row already queued behind it is written to the new bank.
- Ordering: rows are written in arrival order. Row order is not checked; only row ROWS-1 triggers frame end.
- busy = (count != 0) || (state == WRITE).
- Outputs while bram_we = 0: bram_addr and bram_din hold their last values.

Test Plan:
- Reset, then push row 0 with row_data = {40 words, word k = 32'hA000_0000+k} → 40 consecutive writes, addr 0..39, din A000_0000..A000_0027; busy falls after the last write; frame_done stays 0.
- Push row 5 → first write at addr 200, last at addr 239.
- Push row 719 with bank_sel = 0 → writes at addr 28760..28799; frame_done one-cycle pulse after addr 28799; bank_sel = 1. Then push row 0 → addr 28800..28839.
- Hold row_valid for 3 back-to-back rows (0,1,2) → rows 0 and 1 accepted and row_ready = 0. The 3rd row is dropped and err_drop = 1. Writes are 80 contiguous cycles with no bubble between rows 0 and 1.
- Push row_addr = 720 → no bram_we, FIFO empties, err_drop = 1.
- Assert out_stream_aresetn = 0 mid-row (k = 17) → bram_we = 0 immediately. After release: row_ready = 1, busy = 0, bank_sel = 0, err_drop = 0.
